// File: rtl/qc_ldpc_encoder.sv
// qc_ldpc_encoder: systematic QC-LDPC encoder with weight-1 circulant parity generation
//   Parameters: Z bits per block, KB info blocks, MB parity blocks, SW-bit shift entries,
//   and SHIFT_TABLE, where entry (k,j) sits at [(k*MB+j)*SW +: SW] and all-ones means a zero circulant.
//   Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data carry the info blocks in;
//   out_valid/out_ready/out_data/out_last carry KB info words and then MB parity words out.
//   out_last marks the final parity word of each codeword.
module qc_ldpc_encoder #(
   parameter int Z = 8,
   parameter int KB = 4,
   parameter int MB = 2,
   parameter int SW = 4,
   parameter logic [KB*MB*SW-1:0] SHIFT_TABLE = 32'h7F53F210
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [Z-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [Z-1:0] out_data,
   output logic         out_last
);
   localparam int BMAX = (KB > MB) ? KB : MB;
   localparam int BW = (BMAX > 1) ? $clog2(BMAX) : 1;
   typedef enum logic {INFO, PARITY} state_t;
   state_t state_q, state_d;
   logic [BW-1:0] blk_cnt_q, blk_cnt_d;
   logic [MB-1:0][Z-1:0] acc_q, acc_d;
   logic out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic [Z-1:0] out_data_q, out_data_d, par_sel;
   logic load_ok;
   // Rotate right by s; the all-ones shift encodes the zero circulant
   function automatic logic [Z-1:0] rot(input logic [Z-1:0] u, input logic [SW-1:0] s);
      return (s == '1) ? '0 : ((u >> s) | (u << (Z - int'(s))));
   endfunction
   assign load_ok = !out_valid_q || out_ready;
   assign in_ready = (state_q == INFO) && load_ok;
   assign out_valid = out_valid_q;
   assign out_data = out_data_q;
   assign out_last = out_last_q;
   always_comb begin
      par_sel = acc_q[0];
      for (int j = 1; j < MB; j++) if (blk_cnt_q == BW'(j)) par_sel = acc_q[j];
   end
   always_comb begin
      state_d = state_q;
      blk_cnt_d = blk_cnt_q;
      acc_d = acc_q;
      // A consumed word with nothing new to load drops valid; a stalled word holds
      out_valid_d = out_valid_q && !out_ready;
      out_data_d = out_data_q;
      out_last_d = out_last_q;
      if (state_q == INFO) begin
         if (in_valid && in_ready) begin
            out_valid_d = 1'b1;
            out_data_d = in_data;
            out_last_d = 1'b0;
            for (int k = 0; k < KB; k++)
               for (int j = 0; j < MB; j++)
                  if (blk_cnt_q == BW'(k)) acc_d[j] = acc_q[j] ^ rot(in_data, SHIFT_TABLE[(k*MB+j)*SW +: SW]);
            if (blk_cnt_q == BW'(KB-1)) begin
               blk_cnt_d = '0;
               state_d = PARITY;
            end else begin
               blk_cnt_d = blk_cnt_q + BW'(1);
            end
         end
      end else if (load_ok) begin
         out_valid_d = 1'b1;
         out_data_d = par_sel;
         out_last_d = (blk_cnt_q == BW'(MB-1));
         if (blk_cnt_q == BW'(MB-1)) begin
            acc_d = '0;
            blk_cnt_d = '0;
            state_d = INFO;
         end else begin
            blk_cnt_d = blk_cnt_q + BW'(1);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= INFO;
         blk_cnt_q <= '0;
         acc_q <= '0;
         out_valid_q <= 1'b0;
         out_data_q <= '0;
         out_last_q <= 1'b0;
      end else begin
         state_q <= state_d;
         blk_cnt_q <= blk_cnt_d;
         acc_q <= acc_d;
         out_valid_q <= out_valid_d;
         out_data_q <= out_data_d;
         out_last_q <= out_last_d;
      end
   end
endmodule

// File: tb/tb_qc_ldpc_encoder.sv
// tb_qc_ldpc_encoder: directed and randomized checks of qc_ldpc_encoder
module tb_qc_ldpc_encoder;
   logic clk = 1'b0;
   logic rst, in_valid, in_ready, out_valid, out_ready, out_last;
   logic [7:0] in_data, out_data;
   int checks = 0;
   int errors = 0;
   int sh [4][2] = '{'{0, 1}, '{2, 15}, '{3, 5}, '{15, 7}};
   qc_ldpc_encoder dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic exp_out(input string tag, input logic [7:0] d, input logic l);
      chk({tag, " valid"}, out_valid, 1);
      chk({tag, " data"}, out_data, d);
      chk({tag, " last"}, out_last, l);
   endtask
   task automatic run_cw(input string tag, input logic [31:0] info, input logic [15:0] par);
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         in_data = info[k*8 +: 8];
         #1 chk($sformatf("%s rdy%0d", tag, k), in_ready, 1);
         @(negedge clk);
         exp_out($sformatf("%s info%0d", tag, k), info[k*8 +: 8], 1'b0);
         in_valid = 1'b0;
      end
      #1 chk({tag, " parity rdy"}, in_ready, 0);
      @(negedge clk);
      exp_out({tag, " par0"}, par[7:0], 1'b0);
      @(negedge clk);
      exp_out({tag, " par1"}, par[15:8], 1'b1);
      @(negedge clk);
      chk({tag, " idle"}, out_valid, 0);
   endtask
   function automatic logic [7:0] mrot(input logic [7:0] u, input int s);
      logic [7:0] r = '0;
      if (s == 15) return '0;
      for (int i = 0; i < 8; i++) r[i] = u[(i + s) % 8];
      return r;
   endfunction
   initial begin
      logic [7:0] src [8];
      logic [7:0] seq [12];
      logic [7:0] cw [4];
      logic [7:0] p0, p1;
      logic [8:0] q [$];
      logic [8:0] e;
      logic acc;
      int si, nacc, ncyc;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      in_data = '0;
      repeat (2) @(negedge clk);
      chk("reset valid", out_valid, 0);
      chk("reset data", out_data, 0);
      chk("reset last", out_last, 0);
      chk("reset rdy", in_ready, 1);
      rst = 1'b0;
      run_cw("t1", 32'h00000001, 16'h8001);
      run_cw("t2a", 32'h00010000, 16'h0820);
      run_cw("t2b", 32'hFFFFFFFF, 16'hFFFF);
      src = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
      seq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h80, 8'h00, 8'h00, 8'h01, 8'h00, 8'h20, 8'h08};
      si = 0;
      in_valid = 1'b1;
      in_data = src[0];
      for (int c = 0; c < 13; c++) begin
         acc = in_valid && in_ready;
         @(negedge clk);
         if (acc) si++;
         if (c < 12) exp_out($sformatf("t3 w%0d", c), seq[c], (c == 5) || (c == 11));
         in_valid = si < 8;
         in_data = (si < 8) ? src[si] : 8'h00;
      end
      chk("t3 blocks", si, 8);
      chk("t3 idle", out_valid, 0);
      in_valid = 1'b1;
      in_data = 8'h02;
      @(negedge clk);
      exp_out("t4 info0", 8'h02, 1'b0);
      in_data = 8'h04;
      out_ready = 1'b0;
      #1 chk("t4 stall rdy", in_ready, 0);
      @(negedge clk);
      exp_out("t4 held info0", 8'h02, 1'b0);
      out_ready = 1'b1;
      #1 chk("t4 resume rdy", in_ready, 1);
      @(negedge clk);
      exp_out("t4 info1", 8'h04, 1'b0);
      in_data = 8'h01;
      @(negedge clk);
      exp_out("t4 info2", 8'h01, 1'b0);
      in_data = 8'h08;
      @(negedge clk);
      exp_out("t4 info3", 8'h08, 1'b0);
      in_valid = 1'b0;
      @(negedge clk);
      exp_out("t4 par0", 8'h23, 1'b0);
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         exp_out($sformatf("t4 frozen%0d", c), 8'h23, 1'b0);
         chk($sformatf("t4 frozen rdy%0d", c), in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      exp_out("t4 par1", 8'h19, 1'b1);
      @(negedge clk);
      chk("t4 idle", out_valid, 0);
      in_valid = 1'b1;
      in_data = 8'h55;
      @(negedge clk);
      exp_out("t5 info0", 8'h55, 1'b0);
      in_data = 8'hAA;
      @(negedge clk);
      exp_out("t5 info1", 8'hAA, 1'b0);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("t5 rst valid", out_valid, 0);
      chk("t5 rst data", out_data, 0);
      chk("t5 rst last", out_last, 0);
      rst = 1'b0;
      run_cw("t5", 32'h00000001, 16'h8001);
      nacc = 0;
      ncyc = 0;
      while ((nacc < 600 || q.size() > 0) && ncyc < 20000) begin
         out_ready = $urandom_range(0, 3) != 0;
         in_valid = (nacc < 600) && ($urandom_range(0, 3) != 0);
         in_data = 8'($urandom);
         #1;
         if (out_valid && out_ready) begin
            chk("t6 word expected", q.size() > 0, 1);
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("t6 word", {out_last, out_data}, e);
            end
         end
         if (in_valid && in_ready) begin
            cw[nacc % 4] = in_data;
            q.push_back({1'b0, in_data});
            nacc++;
            if (nacc % 4 == 0) begin
               p0 = '0;
               p1 = '0;
               for (int k = 0; k < 4; k++) begin
                  p0 ^= mrot(cw[k], sh[k][0]);
                  p1 ^= mrot(cw[k], sh[k][1]);
               end
               q.push_back({1'b0, p0});
               q.push_back({1'b1, p1});
            end
         end
         @(negedge clk);
         ncyc++;
      end
      chk("t6 accepted", nacc, 600);
      chk("t6 drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
